multi_channel_calibration: RTL and testbench
============================================

Name: multi_channel_calibration

Overview:
- Per-channel ADC calibration stage for the AdcProcessing signal chain. It takes the interleaved multi-channel stream from the ADC interface and feeds the filters and controllers.
- Applies saturating offset, then fixed-point gain with rounding, then final saturation, using coefficients selected by the beat's dest (channel) field.
- Fully pipelined, one beat per clock, with full AXI-stream backpressure and a synchronous pipeline flush.

Parameters:
- DATA_PATH_WIDTH, 16, signed sample width in and out
- N_CHANNELS, 4, number of calibrated channels (dest 0..N_CHANNELS-1)
- GAIN_WIDTH, 16, signed gain coefficient width
- GAIN_FRAC, 12, fractional bits of gain (unity = 2^GAIN_FRAC)
- DEST_WIDTH, 8, width of stream dest field

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pipeline_flush  in  1  synchronous, drops all in-flight beats
- offsets  in  N_CHANNELS x DATA_PATH_WIDTH  signed per-channel offset
- gains  in  N_CHANNELS x GAIN_WIDTH  signed per-channel gain, Q(GAIN_WIDTH-GAIN_FRAC).GAIN_FRAC
- gain_enable  in  N_CHANNELS  per-channel gain enable; 0 = offset only
- data_in  axi_stream.slave  data/dest/valid/ready  raw samples, dest = channel
- data_out  axi_stream.master  data/dest/valid/ready  calibrated samples, dest passed through
- saturation_event  out  1  one-cycle pulse when the beat leaving stage 3 was clamped in any stage
- dest_error  out  1  sticky flag: a beat arrived with dest >= N_CHANNELS

Behaviour:
- One clock domain.
- Reset (reset=1 at a rising edge) clears all stage valids, data, dest, saturation_event and dest_error to 0.
- data_in.ready is 0 during reset.
- Pipeline stages:
  - S1: sum = data + offsets[dest], saturated to [-2^(DW-1), 2^(DW-1)-1].
  - S2: prod = sum * gains[dest], full width DW+GW. Then rnd = (prod + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC (round half up, arithmetic shift).
  - S3: rnd saturated to DW; output = S3 result if gain_enable[dest], else S1 sum.
- Latency: exactly 3 clocks from accepted input beat to data_out.valid when not stalled.
- Coefficients are sampled in the stage that uses them; changing a coefficient affects only beats entering that stage afterwards.
- Handshake:
  - advance = ~data_out.valid | data_out.ready.
  - All stages shift together when advance=1.
  - data_in.ready = advance & ~reset.
  - Input accepted on data_in.valid & data_in.ready.
  - While data_out.valid & ~data_out.ready, data_out.data and data_out.dest stay stable and no stage changes.
  - Bubbles propagate as valid=0 stages. No beat is lost, duplicated or reordered.
- Invalid dest (>= N_CHANNELS):
  - Beat passes with offset 0, gain bypassed, dest unchanged.
  - dest_error set, held until reset.
- Saturation: each beat carries a sat bit (S1 clamp OR S3 clamp, the latter only when gain enabled). saturation_event = sat of the beat leaving S3, pulsed once per output beat, on the cycle data_out.valid first rises for it.
- pipeline_flush:
  - Clears all stage valids and data_out.valid in the same edge.
  - The input beat presented in that cycle is not accepted (data_in.ready=0).
  - flush takes priority over advance.
  - dest_error is not cleared by flush.
- Reset takes priority over flush.
- Reset mid-stream: all in-flight beats are discarded, and the output is idle on the next cycle.

Decomposition:
- Shared package calibration_pkg holds:
  - function sat_signed(value, width)
  - the round-half-up shift function
  - the localparam unity gain, 2^GAIN_FRAC
- One natural sub-module: calibration_gain_stage, containing the multiply, round and saturate (S2+S3). It gives the DSP inference a clear boundary and can be reused by the single-channel path.
- Offset saturation reuses the existing saturating_adder.

Test Plan:
- All scenarios use defaults (DW=16, GAIN_FRAC=12).
- Ch0 offset=100, gain=4096, enabled; input 1000, dest 0 -> output 1100, dest 0, exactly 3 clocks after acceptance, saturation_event=0.
- Ch1 offset=1000; input 32000 -> 32767, saturation_event pulse. Ch2 gain=8192, enabled; inputs 20000 and -20000 -> 32767 and -32768, each with a pulse.
- Ch3 gain=6144 (1.5), offset 0, enabled; inputs 3 and -3 -> 5 and -4 (round half up). With gain_enable[3]=0 the same inputs give 3 and -3.
- Backpressure: 8 back-to-back beats on rotating dest 0..3, data_out.ready low for 5 cycles mid-stream:
  - all 8 outputs correct and in order
  - output data/dest stable while stalled
  - data_in.ready low only while the pipe is full and stalled
- Beat with dest=7: output equals raw input, dest=7, and dest_error=1 remains set after later valid beats; a reset clears it.
- pipeline_flush with 3 beats in flight -> no output beats for them, data_out.valid=0 next cycle, the next accepted beat emerges 3 clocks later. Assert reset mid-stream -> same idle result, with all outputs at 0.

Source files
------------

// File: rtl/calibration_pkg.sv
// Shared helpers for the ADC calibration datapath.
// Contents:
//   wide_t              - 64-bit signed working type for intermediate arithmetic
//   UnityGain           - gain coefficient equal to 1.0 at the default fractional width
//   sat_signed()        - clamp a wide value into a signed field of the given width
//   round_half_up_shift - add half an LSB then arithmetic-shift right by frac bits
package calibration_pkg;

    localparam int unsigned DefaultGainFrac = 12;
    localparam int unsigned UnityGain       = 1 << DefaultGainFrac;

    typedef logic signed [63:0] wide_t;

    function automatic wide_t sat_signed(input wide_t value, input int unsigned width);
        wide_t max_v;
        wide_t min_v;
        max_v = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        min_v = -max_v - wide_t'(1);
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

    // Round half up: ties go towards +infinity, so -1.5 becomes -1.
    function automatic wide_t round_half_up_shift(input wide_t value, input int unsigned frac);
        if (frac == 0) begin
            return value;
        end
        return (value + (wide_t'(1) <<< (frac - 1))) >>> frac;
    endfunction

endpackage

// File: rtl/multi_channel_calibration_if.sv
// AXI-stream style beat interface used by the calibration stage.
// Signals:
//   data  - sample payload
//   dest  - channel number
//   valid - beat present (master to slave)
//   ready - slave can take the beat (slave to master)
interface axi_stream #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEST_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  valid;
    logic                  ready;

    modport master (output data, output dest, output valid, input ready);
    modport slave  (input data, input dest, input valid, output ready);
endinterface

// File: rtl/calibration_gain_stage.sv
// Stages 2 and 3 of the calibration pipe: gain multiply with round-half-up,
// then output saturation and gain-enable select.
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   flush_i             - drop in-flight beats
//   advance_i           - whole pipe shifts this cycle
//   valid_i/sum_i/...   - stage-1 beat (offset-corrected sum, dest, clamp flag)
//   gains_i             - per-channel gain, sampled in stage 2
//   gain_enable_i       - per-channel enable, sampled in stage 3
//   valid_o/data_o/...  - stage-3 registered beat
//   sat_event_o         - pulse on the first cycle a clamped beat is presented
module calibration_gain_stage
    import calibration_pkg::*;
#(
    parameter int unsigned DATA_PATH_WIDTH = 16,
    parameter int unsigned N_CHANNELS      = 4,
    parameter int unsigned GAIN_WIDTH      = 16,
    parameter int unsigned GAIN_FRAC       = 12,
    parameter int unsigned DEST_WIDTH      = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  flush_i,
    input  logic                                  advance_i,
    input  logic                                  valid_i,
    input  logic [DATA_PATH_WIDTH-1:0]            sum_i,
    input  logic [DEST_WIDTH-1:0]                 dest_i,
    input  logic                                  sat_i,
    input  logic [N_CHANNELS-1:0][GAIN_WIDTH-1:0] gains_i,
    input  logic [N_CHANNELS-1:0]                 gain_enable_i,
    output logic                                  valid_o,
    output logic [DATA_PATH_WIDTH-1:0]            data_o,
    output logic [DEST_WIDTH-1:0]                 dest_o,
    output logic                                  sat_event_o
);
    localparam int unsigned ProdWidth = DATA_PATH_WIDTH + GAIN_WIDTH;
    localparam int unsigned ChIdxW    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam logic [DEST_WIDTH-1:0] NumCh = DEST_WIDTH'(N_CHANNELS);

    // Stage 2 next-state
    logic                        s2_dest_ok;
    logic [GAIN_WIDTH-1:0]       gain_sel;
    logic signed [ProdWidth-1:0] prod;
    wide_t                       rnd_wide;
    logic signed [ProdWidth-1:0] s2_rnd_d;

    // Stage 2 registers
    logic                        s2_valid_q;
    logic signed [ProdWidth-1:0] s2_rnd_q;
    logic [DATA_PATH_WIDTH-1:0]  s2_sum_q;
    logic [DEST_WIDTH-1:0]       s2_dest_q;
    logic                        s2_sat_q;

    // Stage 3 next-state
    logic                        s3_dest_ok;
    logic                        gain_on;
    wide_t                       rnd_sat;
    logic                        gain_clamped;
    logic [DATA_PATH_WIDTH-1:0]  s3_data_d;
    logic                        s3_sat_d;

    // Stage 3 registers
    logic                        s3_valid_q;
    logic [DATA_PATH_WIDTH-1:0]  s3_data_q;
    logic [DEST_WIDTH-1:0]       s3_dest_q;
    logic                        sat_event_q;

    always_comb begin
        s2_dest_ok = (dest_i < NumCh);
        gain_sel   = '0;
        if (s2_dest_ok) begin
            gain_sel = gains_i[ChIdxW'(dest_i)];
        end
        prod     = $signed(sum_i) * $signed(gain_sel);
        rnd_wide = round_half_up_shift(wide_t'(prod), GAIN_FRAC);
        // The rounded quotient is narrower than the product, so this slice is lossless.
        s2_rnd_d = rnd_wide[ProdWidth-1:0];
    end

    always_comb begin
        s3_dest_ok = (s2_dest_q < NumCh);
        gain_on    = 1'b0;
        if (s3_dest_ok) begin
            gain_on = gain_enable_i[ChIdxW'(s2_dest_q)];
        end
        rnd_sat      = sat_signed(wide_t'(s2_rnd_q), DATA_PATH_WIDTH);
        gain_clamped = (rnd_sat != wide_t'(s2_rnd_q));
        s3_data_d    = gain_on ? rnd_sat[DATA_PATH_WIDTH-1:0] : s2_sum_q;
        // Gain-stage clamping only matters when the gained value is actually used.
        s3_sat_d     = s2_sat_q | (gain_on & gain_clamped);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid_q  <= 1'b0;
            s2_rnd_q    <= '0;
            s2_sum_q    <= '0;
            s2_dest_q   <= '0;
            s2_sat_q    <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_data_q   <= '0;
            s3_dest_q   <= '0;
            sat_event_q <= 1'b0;
        end else if (flush_i) begin
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            sat_event_q <= 1'b0;
        end else if (advance_i) begin
            s2_valid_q  <= valid_i;
            s2_rnd_q    <= s2_rnd_d;
            s2_sum_q    <= sum_i;
            s2_dest_q   <= dest_i;
            s2_sat_q    <= sat_i;
            s3_valid_q  <= s2_valid_q;
            s3_data_q   <= s3_data_d;
            s3_dest_q   <= s2_dest_q;
            sat_event_q <= s2_valid_q & s3_sat_d;
        end else begin
            // Stalled: the beat stays presented but its event has already pulsed.
            sat_event_q <= 1'b0;
        end
    end

    assign valid_o     = s3_valid_q;
    assign data_o      = s3_data_q;
    assign dest_o      = s3_dest_q;
    assign sat_event_o = sat_event_q;
endmodule

// File: rtl/saturating_adder.sv
// Combinational signed adder with saturation to the operand width.
// Ports:
//   a_i, b_i - signed operands
//   sum_o    - saturated sum
//   sat_o    - high when the exact sum did not fit and was clamped
module saturating_adder
    import calibration_pkg::*;
#(
    parameter int unsigned Width = 16
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] sum_o,
    output logic             sat_o
);
    wide_t exact;
    wide_t clamped;

    always_comb begin
        exact   = wide_t'($signed(a_i)) + wide_t'($signed(b_i));
        clamped = sat_signed(exact, Width);
        sum_o   = clamped[Width-1:0];
        sat_o   = (clamped != exact);
    end
endmodule

// File: rtl/multi_channel_calibration.sv
// Per-channel ADC calibration: saturating offset, fixed-point gain with
// round-half-up, final saturation. Three-stage pipe with AXI-stream backpressure.
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   pipeline_flush    - drop all in-flight beats
//   offsets           - per-channel signed offset (stage 1)
//   gains             - per-channel signed gain, GAIN_FRAC fractional bits (stage 2)
//   gain_enable       - per-channel gain enable, 0 = offset only (stage 3)
//   data_in           - raw samples, dest selects the channel
//   data_out          - calibrated samples, dest passed through
//   saturation_event  - pulse when the presented output beat was clamped anywhere
//   dest_error        - sticky: a beat arrived with an out-of-range dest
module multi_channel_calibration
    import calibration_pkg::*;
#(
    parameter int unsigned DATA_PATH_WIDTH = 16,
    parameter int unsigned N_CHANNELS      = 4,
    parameter int unsigned GAIN_WIDTH      = 16,
    parameter int unsigned GAIN_FRAC       = DefaultGainFrac,
    parameter int unsigned DEST_WIDTH      = 8
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       pipeline_flush,
    input  logic [N_CHANNELS-1:0][DATA_PATH_WIDTH-1:0] offsets,
    input  logic [N_CHANNELS-1:0][GAIN_WIDTH-1:0]      gains,
    input  logic [N_CHANNELS-1:0]                      gain_enable,
    axi_stream.slave                                   data_in,
    axi_stream.master                                  data_out,
    output logic                                       saturation_event,
    output logic                                       dest_error
);
    localparam int unsigned ChIdxW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam logic [DEST_WIDTH-1:0] NumCh = DEST_WIDTH'(N_CHANNELS);

    logic                       out_valid;
    logic [DATA_PATH_WIDTH-1:0] out_data;
    logic [DEST_WIDTH-1:0]      out_dest;
    logic                       out_sat_event;

    logic                       advance;
    logic                       accept;
    logic                       in_dest_ok;
    logic [DATA_PATH_WIDTH-1:0] offset_sel;
    logic [DATA_PATH_WIDTH-1:0] s1_sum_d;
    logic                       s1_sat_d;

    logic                       s1_valid_q;
    logic [DATA_PATH_WIDTH-1:0] s1_data_q;
    logic [DEST_WIDTH-1:0]      s1_dest_q;
    logic                       s1_sat_q;
    logic                       dest_error_q;

    // Single global enable: every stage moves unless the output is held.
    assign advance       = ~out_valid | data_out.ready;
    assign data_in.ready = advance & ~reset & ~pipeline_flush;
    assign accept        = data_in.valid & advance & ~reset & ~pipeline_flush;

    always_comb begin
        in_dest_ok = (data_in.dest < NumCh);
        offset_sel = '0;
        if (in_dest_ok) begin
            offset_sel = offsets[ChIdxW'(data_in.dest)];
        end
    end

    saturating_adder #(
        .Width (DATA_PATH_WIDTH)
    ) u_offset_add (
        .a_i   (data_in.data),
        .b_i   (offset_sel),
        .sum_o (s1_sum_d),
        .sat_o (s1_sat_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_dest_q  <= '0;
            s1_sat_q   <= 1'b0;
        end else if (pipeline_flush) begin
            s1_valid_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= accept;
            s1_data_q  <= s1_sum_d;
            s1_dest_q  <= data_in.dest;
            s1_sat_q   <= s1_sat_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dest_error_q <= 1'b0;
        end else if (accept && !in_dest_ok) begin
            dest_error_q <= 1'b1;
        end
    end

    calibration_gain_stage #(
        .DATA_PATH_WIDTH (DATA_PATH_WIDTH),
        .N_CHANNELS      (N_CHANNELS),
        .GAIN_WIDTH      (GAIN_WIDTH),
        .GAIN_FRAC       (GAIN_FRAC),
        .DEST_WIDTH      (DEST_WIDTH)
    ) u_gain_stage (
        .clock         (clock),
        .reset         (reset),
        .flush_i       (pipeline_flush),
        .advance_i     (advance),
        .valid_i       (s1_valid_q),
        .sum_i         (s1_data_q),
        .dest_i        (s1_dest_q),
        .sat_i         (s1_sat_q),
        .gains_i       (gains),
        .gain_enable_i (gain_enable),
        .valid_o       (out_valid),
        .data_o        (out_data),
        .dest_o        (out_dest),
        .sat_event_o   (out_sat_event)
    );

    assign data_out.valid   = out_valid;
    assign data_out.data    = out_data;
    assign data_out.dest    = out_dest;
    assign saturation_event = out_sat_event;
    assign dest_error       = dest_error_q;
endmodule

// File: tb/tb_multi_channel_calibration.sv
// Bench for multi_channel_calibration: directed steps followed by randomized
// traffic, checked against an arithmetic reference model and a beat scoreboard.
module tb_multi_channel_calibration;
    import calibration_pkg::*;

    localparam int DW    = 16;
    localparam int NC    = 4;
    localparam int GW    = 16;
    localparam int GF    = 12;
    localparam int DESTW = 8;
    localparam int Hi    = (1 << (DW - 1)) - 1;
    localparam int Lo    = -(1 << (DW - 1));

    logic clock = 1'b0;
    logic reset;
    logic flush;
    logic [NC-1:0][DW-1:0] offsets;
    logic [NC-1:0][GW-1:0] gains;
    logic [NC-1:0]         gain_enable;
    logic                  sat_event;
    logic                  dest_error;

    axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(DESTW)) in_if ();
    axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(DESTW)) out_if ();

    multi_channel_calibration #(
        .DATA_PATH_WIDTH (DW),
        .N_CHANNELS      (NC),
        .GAIN_WIDTH      (GW),
        .GAIN_FRAC       (GF),
        .DEST_WIDTH      (DESTW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .pipeline_flush   (flush),
        .offsets          (offsets),
        .gains            (gains),
        .gain_enable      (gain_enable),
        .data_in          (in_if),
        .data_out         (out_if),
        .saturation_event (sat_event),
        .dest_error       (dest_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int data;
        int dest;
        bit sat;
    } beat_t;

    int    off_m  [NC];
    int    gain_m [NC];
    bit    en_m   [NC];
    beat_t exp_q  [$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;
    logic [DW-1:0]    prev_data  = '0;
    logic [DESTW-1:0] prev_dest  = '0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic with floor division for the rounding.
    function automatic beat_t model(input int data, input int dest);
        beat_t  r;
        longint s;
        longint p;
        longint q;
        r.dest = dest;
        r.sat  = 1'b0;
        if (dest >= NC) begin
            r.data = data;
            return r;
        end
        s = longint'(data) + longint'(off_m[dest]);
        if (s > Hi) begin s = Hi; r.sat = 1'b1; end
        else if (s < Lo) begin s = Lo; r.sat = 1'b1; end
        if (!en_m[dest]) begin
            r.data = int'(s);
            return r;
        end
        p = s * longint'(gain_m[dest]) + longint'(1 << (GF - 1));
        q = p / longint'(1 << GF);
        if ((p % longint'(1 << GF)) != 0 && p < 0) q = q - 1;
        if (q > Hi) begin q = Hi; r.sat = 1'b1; end
        else if (q < Lo) begin q = Lo; r.sat = 1'b1; end
        r.data = int'(q);
        return r;
    endfunction

    task automatic apply_coeffs();
        for (int i = 0; i < NC; i++) begin
            offsets[i]     = off_m[i][DW-1:0];
            gains[i]       = gain_m[i][GW-1:0];
            gain_enable[i] = en_m[i];
        end
    endtask

    // Output monitor and scoreboard, sampled mid-cycle.
    always @(negedge clock) begin : mon
        beat_t b;
        if (reset) begin
            exp_q.delete();
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (out_if.valid) begin
                if (prev_valid && !prev_ready) begin
                    check("hold_data", $signed(out_if.data), $signed(prev_data));
                    check("hold_dest", out_if.dest, prev_dest);
                    check("sat_once", sat_event, 0);
                end else begin
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("sat_event", sat_event, exp_q[0].sat);
                end
                if (out_if.ready && exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check("out_data", $signed(out_if.data), b.data);
                    check("out_dest", out_if.dest, b.dest);
                end
            end else begin
                check("sat_idle", sat_event, 0);
            end
            prev_valid = out_if.valid;
            prev_ready = out_if.ready;
            prev_data  = out_if.data;
            prev_dest  = out_if.dest;
            if (flush) exp_q.delete();
            else if (in_if.valid && in_if.ready)
                exp_q.push_back(model($signed(in_if.data), int'(in_if.dest)));
        end
    end

    // All tasks begin and end one time unit after a rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        in_if.valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int data, input int dest);
        int guard;
        guard        = 0;
        in_if.data   = data[DW-1:0];
        in_if.dest   = dest[DESTW-1:0];
        in_if.valid  = 1'b1;
        #1;
        while (!in_if.ready && guard < 50) begin
            @(posedge clock);
            #2;
            guard++;
        end
        if (guard >= 50) check("accept_timeout", guard, 0);
        step();
        in_if.valid = 1'b0;
    endtask

    task automatic send_and_time(input int data, input int dest, output int lat);
        in_if.data  = data[DW-1:0];
        in_if.dest  = dest[DESTW-1:0];
        in_if.valid = 1'b1;
        #1;
        check("idle_ready", in_if.ready, 1);
        step();
        in_if.valid = 1'b0;
        lat = 1;
        while (!out_if.valid && lat < 10) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int sent;
        int cyc;
        int guard;
        bit acc;
        bit exp_ready;

        reset = 1'b1; flush = 1'b0;
        in_if.valid = 1'b0; in_if.data = '0; in_if.dest = '0;
        out_if.ready = 1'b1;
        off_m  = '{100, 1000, 0, 0};
        gain_m = '{UnityGain, UnityGain, 8192, 6144};
        en_m   = '{1'b1, 1'b1, 1'b1, 1'b1};
        apply_coeffs();
        repeat (3) step();
        #1;
        check("rst_in_ready", in_if.ready, 0);
        check("rst_valid", out_if.valid, 0);
        check("rst_data", out_if.data, 0);
        check("rst_dest", out_if.dest, 0);
        check("rst_sat", sat_event, 0);
        check("rst_dest_err", dest_error, 0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_ready", in_if.ready, 1);
        step();

        // Unity-gain channel with offset: 1000 + 100 -> 1100 after three clocks.
        send_and_time(1000, 0, lat);
        check("latency", lat, 3);
        idle(4);

        // Saturation on offset, on gain, and round-half-up.
        send(32000, 1);
        send(20000, 2);
        send(-20000, 2);
        send(3, 3);
        send(-3, 3);
        idle(6);
        en_m[3] = 1'b0;
        apply_coeffs();
        send(3, 3);
        send(-3, 3);
        idle(6);
        check("directed_drained", exp_q.size(), 0);

        // Backpressure: 8 back-to-back beats, output stalled for 5 cycles.
        en_m[3] = 1'b1;
        apply_coeffs();
        sent = 0;
        cyc  = 0;
        while (sent < 8 && cyc < 100) begin
            in_if.valid  = 1'b1;
            in_if.data   = 16'($urandom);
            in_if.dest   = 8'(sent % NC);
            out_if.ready = !(cyc >= 5 && cyc < 10);
            #1;
            exp_ready = !(!out_if.ready && exp_q.size() == 3);
            check("bp_in_ready", in_if.ready, exp_ready);
            acc = in_if.valid && in_if.ready;
            step();
            if (acc) sent++;
            cyc++;
        end
        check("bp_all_sent", sent, 8);
        out_if.ready = 1'b1;
        idle(6);
        check("bp_drained", exp_q.size(), 0);

        // Out-of-range dest passes raw and sets the sticky error.
        send(-12345, 7);
        idle(5);
        check("dest_err_set", dest_error, 1);
        send(500, 0);
        send(1, 1);
        idle(5);
        check("dest_err_sticky", dest_error, 1);

        // Flush with three beats held in the pipe.
        out_if.ready = 1'b0;
        send(111, 0);
        send(222, 1);
        send(333, 2);
        in_if.valid = 1'b1;
        in_if.data  = 16'd444;
        in_if.dest  = 8'd3;
        flush       = 1'b1;
        #1;
        check("flush_in_ready", in_if.ready, 0);
        check("flush_pre_valid", out_if.valid, 1);
        step();
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        #1;
        check("flush_valid", out_if.valid, 0);
        check("flush_keeps_err", dest_error, 1);
        idle(3);
        send_and_time(-700, 1, lat);
        check("flush_latency", lat, 3);
        idle(4);

        // Reset mid-stream.
        out_if.ready = 1'b0;
        send(1234, 1);
        send(-4321, 2);
        send(77, 3);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", in_if.ready, 0);
        step();
        reset = 1'b0;
        out_if.ready = 1'b1;
        #1;
        check("mid_rst_valid", out_if.valid, 0);
        check("mid_rst_data", out_if.data, 0);
        check("mid_rst_dest", out_if.dest, 0);
        check("mid_rst_sat", sat_event, 0);
        check("mid_rst_dest_err", dest_error, 0);
        step();

        // Randomized rounds with fresh coefficients each round.
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < NC; i++) begin
                off_m[i]  = int'($signed(16'($urandom)));
                gain_m[i] = int'($signed(16'($urandom)));
                en_m[i]   = 1'($urandom);
            end
            apply_coeffs();
            acc = 1'b1;
            for (int c = 0; c < 80; c++) begin
                if (acc || !in_if.valid) begin
                    in_if.valid = ($urandom_range(0, 9) < 7);
                    in_if.data  = 16'($urandom);
                    in_if.dest  = 8'($urandom_range(0, 5));
                end
                out_if.ready = ($urandom_range(0, 3) != 0);
                #1;
                acc = in_if.valid && in_if.ready;
                step();
            end
            in_if.valid  = 1'b0;
            out_if.ready = 1'b1;
            guard = 0;
            while (exp_q.size() != 0 && guard < 50) begin
                step();
                guard++;
            end
            step();
            check("rand_drained", exp_q.size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
